// File: rtl/pwm_capture.sv
// PWM period/high-time capture with a 4-register memory-mapped bus.
// The input is synchronized, edge-detected, and measured rise-to-rise in clk cycles.
module pwm_capture #(
   parameter int WIDTH = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic [31:0] mem_rdata,
   input  logic        pwm_in
);

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_HIGH   = 2'd2;
   localparam logic [1:0] ADDR_PERIOD = 2'd3;

   localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } state_t;

   state_t           state_reg;
   logic             sync1_reg;
   logic             sync2_reg;
   logic             prev_reg;
   logic             en_reg;
   logic             valid_reg;
   logic             ovf_reg;
   logic [WIDTH-1:0] period_cnt_reg;
   logic [WIDTH-1:0] high_cnt_reg;
   logic [WIDTH-1:0] high_reg;
   logic [WIDTH-1:0] period_reg;

   logic             rise;
   logic             bus_access;
   logic             bus_write;
   logic [1:0]       reg_sel;
   logic             ctrl_wr;
   logic             status_wr;
   logic             capture_now;
   logic             ovf_now;
   logic [31:0]      rdata_next;
   logic             unused_ok;

   assign rise        = sync2_reg & ~prev_reg;
   assign bus_access  = mem_valid & ~mem_ready;
   assign bus_write   = bus_access & (|mem_wstrb);
   assign reg_sel     = mem_addr[3:2];
   assign ctrl_wr     = bus_write && (reg_sel == ADDR_CTRL);
   assign status_wr   = bus_write && (reg_sel == ADDR_STATUS);

   // A rise coinciding with a saturated counter cannot be represented in PERIOD,
   // so saturation takes priority and that rise is treated as an overflow.
   assign ovf_now     = (state_reg == MEASURE) && en_reg && (period_cnt_reg == CNT_MAX);
   assign capture_now = (state_reg == MEASURE) && en_reg && rise && (period_cnt_reg != CNT_MAX);

   assign unused_ok   = &{1'b0, mem_addr[31:4], mem_addr[1:0], mem_wdata[31:2]};

   always_comb begin
      rdata_next = 32'd0;
      case (reg_sel)
         ADDR_CTRL:   rdata_next = {31'd0, en_reg};
         ADDR_STATUS: rdata_next = {30'd0, ovf_reg, valid_reg};
         ADDR_HIGH:   rdata_next = 32'(high_reg);
         ADDR_PERIOD: rdata_next = 32'(period_reg);
         default:     rdata_next = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         prev_reg  <= 1'b0;
      end else begin
         sync1_reg <= pwm_in;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_ready <= 1'b0;
         mem_rdata <= 32'd0;
         en_reg    <= 1'b0;
      end else begin
         mem_ready <= bus_access;
         if (bus_access && !bus_write) begin
            mem_rdata <= rdata_next;
         end
         if (ctrl_wr) begin
            en_reg <= mem_wdata[0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         period_cnt_reg <= CNT_ZERO;
         high_cnt_reg   <= CNT_ZERO;
         high_reg       <= CNT_ZERO;
         period_reg     <= CNT_ZERO;
         valid_reg      <= 1'b0;
         ovf_reg        <= 1'b0;
      end else begin
         // Hardware set beats a simultaneous write-1-to-clear.
         if (capture_now) begin
            valid_reg <= 1'b1;
         end else if (status_wr && mem_wdata[0]) begin
            valid_reg <= 1'b0;
         end
         if (ovf_now) begin
            ovf_reg <= 1'b1;
         end else if (status_wr && mem_wdata[1]) begin
            ovf_reg <= 1'b0;
         end
         if (capture_now) begin
            high_reg   <= high_cnt_reg;
            period_reg <= period_cnt_reg + CNT_ONE;
         end

         case (state_reg)
            IDLE: begin
               period_cnt_reg <= CNT_ZERO;
               high_cnt_reg   <= CNT_ZERO;
               if (en_reg) begin
                  state_reg <= ARM;
               end
            end
            ARM: begin
               if (!en_reg) begin
                  state_reg      <= IDLE;
                  period_cnt_reg <= CNT_ZERO;
                  high_cnt_reg   <= CNT_ZERO;
               end else if (rise) begin
                  // The rise cycle itself is high; period's +1 accounts for it on capture.
                  state_reg      <= MEASURE;
                  period_cnt_reg <= CNT_ZERO;
                  high_cnt_reg   <= CNT_ONE;
               end
            end
            MEASURE: begin
               if (!en_reg) begin
                  state_reg      <= IDLE;
                  period_cnt_reg <= CNT_ZERO;
                  high_cnt_reg   <= CNT_ZERO;
               end else if (ovf_now) begin
                  state_reg      <= ARM;
                  period_cnt_reg <= CNT_ZERO;
                  high_cnt_reg   <= CNT_ZERO;
               end else if (rise) begin
                  period_cnt_reg <= CNT_ZERO;
                  high_cnt_reg   <= CNT_ONE;
               end else begin
                  period_cnt_reg <= period_cnt_reg + CNT_ONE;
                  if (sync2_reg && (high_cnt_reg != CNT_MAX)) begin
                     high_cnt_reg <= high_cnt_reg + CNT_ONE;
                  end
               end
            end
            default: begin
               state_reg      <= IDLE;
               period_cnt_reg <= CNT_ZERO;
               high_cnt_reg   <= CNT_ZERO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: bus transactions push expectations,
// a negedge monitor pops and compares whenever mem_ready is seen.
module tb_pwm_capture;

   localparam int WIDTH = 8;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_STATUS = 2'd1;
   localparam logic [1:0] A_HIGH   = 2'd2;
   localparam logic [1:0] A_PERIOD = 2'd3;

   logic        clk;
   logic        rst;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        pwm_in;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      bit          is_read;
      logic [31:0] exp;
      string       name;
   } txn_t;

   txn_t sb_q[$];

   int   pwm_p     = 8;
   int   pwm_h     = 2;
   bit   pwm_on    = 1'b0;
   logic pwm_level = 1'b0;
   int   ph        = 0;

   pwm_capture #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_rdata (mem_rdata),
      .pwm_in    (pwm_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; the access happens on the next edge.
   task automatic bus(input logic [1:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      input logic [31:0] exp, input string name);
      txn_t t;
      t.is_read = (ws == 4'd0);
      t.exp     = exp;
      t.name    = name;
      sb_q.push_back(t);
      mem_valid = 1'b1;
      mem_addr  = {28'h1234560, a, 2'b00};
      mem_wdata = wd;
      mem_wstrb = ws;
      tick(1);
      check({name, "_ready"}, 32'(mem_ready), 32'd1);
      mem_valid = 1'b0;
      mem_wstrb = 4'd0;
      tick(1);
      check({name, "_ready_drop"}, 32'(mem_ready), 32'd0);
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
      bus(a, 32'd0, 4'd0, exp, name);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input string name);
      bus(a, wd, ws, 32'd0, name);
   endtask

   // PWM generator: changes at negedge so every posedge sees a stable level.
   initial begin
      pwm_in = 1'b0;
      forever begin
         @(negedge clk);
         if (pwm_on) begin
            pwm_in = (ph < pwm_h);
            ph     = (ph + 1 == pwm_p) ? 0 : ph + 1;
         end else begin
            pwm_in = pwm_level;
            ph     = 0;
         end
      end
   end

   // Monitor
   initial begin
      txn_t t;
      forever begin
         @(negedge clk);
         if (mem_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("FAIL unexpected_ready: mem_ready=1 with no transaction pending, expected 0");
            end else begin
               t = sb_q.pop_front();
               if (t.is_read) begin
                  check(t.name, mem_rdata, t.exp);
                  $display("[TB] read  %s rdata=%h exp=%h", t.name, mem_rdata, t.exp);
               end else begin
                  $display("[TB] write %s", t.name);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      mem_valid = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      mem_wstrb = 4'd0;
      tick(3);
      check("reset_ready", 32'(mem_ready), 32'd0);
      check("reset_rdata", mem_rdata, 32'd0);
      rst = 1'b0;
      tick(1);
      rd(A_CTRL,   32'd0, "rst_ctrl");
      rd(A_STATUS, 32'd0, "rst_status");
      rd(A_HIGH,   32'd0, "rst_high");
      rd(A_PERIOD, 32'd0, "rst_period");

      // Basic capture, P=8 H=2. Edge e = now: first rise sampled e+1 arms (e+3),
      // second rise sampled e+9 captures at e+11, then every 8 edges.
      wr(A_CTRL, 32'd1, 4'h1, "en_on");
      pwm_p  = 8;
      pwm_h  = 2;
      pwm_on = 1'b1;
      tick(10);
      rd(A_STATUS, 32'd0, "status_at_capture_edge");    // e+11, pre-update
      rd(A_HIGH,   32'd2, "high_p8h2");                 // e+13
      rd(A_PERIOD, 32'd8, "period_p8h2");               // e+15
      wr(A_STATUS, 32'd1, 4'hF, "w1c_valid_a");         // e+17
      tick(1);
      rd(A_STATUS, 32'd1, "status_latency");            // e+20, capture was e+19
      wr(A_STATUS, 32'd1, 4'hF, "w1c_valid_b");         // e+22
      rd(A_STATUS, 32'd0, "status_cleared");            // e+24
      tick(1);
      wr(A_STATUS, 32'd1, 4'hF, "w1c_with_capture");    // e+27, capture edge
      rd(A_STATUS, 32'd1, "valid_beats_w1c");           // e+29

      // Disable mid-period, then re-enable with a new waveform.
      wr(A_CTRL, 32'd0, 4'h2, "en_off");                // e+31
      wr(A_STATUS, 32'd1, 4'hF, "w1c_valid_c");         // e+33
      rd(A_HIGH,   32'd2, "high_kept_off");
      rd(A_PERIOD, 32'd8, "period_kept_off");
      rd(A_STATUS, 32'd0, "no_capture_while_off");      // e+39, would-be capture e+35
      pwm_on = 1'b0;
      tick(2);
      wr(A_CTRL, 32'd1, 4'h4, "en_on_again");
      tick(2);
      pwm_p  = 6;
      pwm_h  = 3;
      pwm_on = 1'b1;                                    // edge e2
      tick(4);
      rd(A_HIGH,   32'd2, "high_retained");             // e2+5
      rd(A_PERIOD, 32'd8, "period_retained");           // e2+7
      rd(A_STATUS, 32'd0, "status_first_fresh_rise");   // e2+9, pre-update
      rd(A_HIGH,   32'd3, "high_p6h3");                 // e2+11
      rd(A_PERIOD, 32'd6, "period_p6h3");
      rd(A_STATUS, 32'd1, "status_p6h3");

      // Register map and read-only registers.
      pwm_on = 1'b0;
      tick(2);
      wr(A_CTRL, 32'd0, 4'h8, "en_off_map");
      rd(A_CTRL,   32'd0, "map_ctrl");
      rd(A_STATUS, 32'd1, "map_status");
      rd(A_HIGH,   32'd3, "map_high");
      rd(A_PERIOD, 32'd6, "map_period");
      wr(A_PERIOD, 32'hFFFFFFFF, 4'hF, "wr_period_ro");
      wr(A_HIGH,   32'hFFFFFFFF, 4'hF, "wr_high_ro");
      rd(A_PERIOD, 32'd6, "period_ro_kept");
      rd(A_HIGH,   32'd3, "high_ro_kept");
      wr(A_CTRL, 32'hFFFFFFFF, 4'hF, "ctrl_all_ones");
      rd(A_CTRL, 32'd1, "ctrl_unused_zero");
      wr(A_CTRL, 32'd0, 4'hF, "ctrl_clear");
      rd(A_CTRL, 32'd0, "ctrl_cleared");

      // Overflow: one rise, then stuck low; OVF ~256 edges after arming.
      wr(A_STATUS, 32'd3, 4'hF, "w1c_both");
      rd(A_STATUS, 32'd0, "status_clear_both");
      wr(A_CTRL, 32'd1, 4'h1, "en_on_ovf");
      tick(2);
      pwm_level = 1'b1;                                 // edge f
      tick(3);
      pwm_level = 1'b0;                                 // armed at f+3
      tick(150);
      rd(A_STATUS, 32'd0, "ovf_not_yet");               // f+154
      tick(145);
      rd(A_STATUS, 32'd2, "ovf_set");                   // f+301
      rd(A_HIGH,   32'd3, "ovf_high_kept");
      rd(A_PERIOD, 32'd6, "ovf_period_kept");
      wr(A_STATUS, 32'd1, 4'hF, "w1c_bit0_only");
      rd(A_STATUS, 32'd2, "ovf_kept_bit1_clear");
      wr(A_STATUS, 32'd2, 4'hF, "w1c_ovf");
      rd(A_STATUS, 32'd0, "ovf_cleared");

      // Reset mid-measurement and mid-transaction.
      pwm_p  = 8;
      pwm_h  = 2;
      pwm_on = 1'b1;                                    // edge e4, still ARM
      tick(20);
      rd(A_STATUS, 32'd1, "valid_before_rst");
      rst       = 1'b1;
      mem_valid = 1'b1;
      mem_addr  = {28'h1234560, A_STATUS, 2'b00};
      mem_wstrb = 4'd0;
      tick(1);
      check("ready_cut_by_reset", 32'(mem_ready), 32'd0);
      rst       = 1'b0;
      mem_valid = 1'b0;
      pwm_on    = 1'b0;
      tick(1);
      check("ready_after_reset", 32'(mem_ready), 32'd0);
      rd(A_CTRL,   32'd0, "post_rst_ctrl");
      rd(A_STATUS, 32'd0, "post_rst_status");
      rd(A_HIGH,   32'd0, "post_rst_high");
      rd(A_PERIOD, 32'd0, "post_rst_period");
      wr(A_CTRL, 32'd1, 4'h1, "en_after_rst");
      tick(2);
      pwm_on = 1'b1;                                    // edge e5
      tick(10);
      rd(A_STATUS, 32'd0, "post_rst_first_capture_edge"); // e5+11
      rd(A_STATUS, 32'd1, "post_rst_valid");
      rd(A_HIGH,   32'd2, "post_rst_high_cap");
      rd(A_PERIOD, 32'd8, "post_rst_period_cap");

      pwm_on = 1'b0;
      tick(3);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 24, meaning the counter/capture width in bits (legal 8..32).
REQ-002 SHALL have port clk  input  1  single clock; all logic posedge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port mem_valid  input  1  bus request.
REQ-005 SHALL have port mem_ready  output  1  bus acknowledge, registered.
REQ-006 SHALL have port mem_addr  input  32  byte address; only bits [3:2] decoded.
REQ-007 SHALL have port mem_wdata  input  32  write data.
REQ-008 SHALL have port mem_wstrb  input  4  write strobes; any nonzero bit means a full-word write; zero means a read.
REQ-009 SHALL have port mem_rdata  output  32  read data, registered.
REQ-010 SHALL have port pwm_in  input  1  measured PWM signal, possibly asynchronous to clk.

Function
REQ-011 SHALL pass pwm_in through a 2-flop synchronizer, then a third "previous" flop; rise = sync & !prev, fall = !sync & prev.
REQ-012 SHALL map registers: addr[3:2]=0 CTRL (bit0 EN, RW); 1 STATUS (bit0 VALID, bit1 OVF; write-1-to-clear); 2 HIGH (RO); 3 PERIOD (RO).
REQ-013 SHALL assert mem_ready for exactly one cycle, on the cycle after mem_valid is first seen (mem_ready <= mem_valid && !mem_ready); mem_valid is held by the master until mem_ready.
REQ-014 SHALL perform the write, and load mem_rdata for a read, on the same edge that raises mem_ready; unused rdata bits read 0.
REQ-015 SHALL ignore writes to HIGH/PERIOD; a STATUS write with bit1 clear SHALL leave OVF unchanged.
REQ-016 SHALL implement states IDLE, ARM and MEASURE.
REQ-017 SHALL hold IDLE while EN=0, with period_cnt and high_cnt held at 0.
REQ-018 SHALL go IDLE->ARM when EN=1.
REQ-019 SHALL go ARM->MEASURE on the first rise, clearing the counters.
REQ-020 SHALL go MEASURE->ARM on counter saturation.
REQ-021 SHALL go from any state to IDLE when EN=0 on the next edge; HIGH, PERIOD and STATUS are retained.
REQ-022 SHALL, in MEASURE, increment period_cnt every cycle and increment high_cnt every cycle that sync=1.
REQ-023 SHALL, on a rise in MEASURE, load PERIOD = period_cnt+1 and HIGH = high_cnt (high cycles of the completed period), set VALID, and restart both counters on the same edge, counting the rise cycle.
REQ-024 SHALL, for a steady input with H high cycles per P-cycle period, capture HIGH=H and PERIOD=P exactly.
REQ-025 SHALL make capture latency = 3 clk edges from the first edge sampling pwm_in high to the HIGH/PERIOD/VALID update.
REQ-026 SHALL, when period_cnt reaches 2^WIDTH-1 without a rise (stuck high/low, or period too long), set OVF, leave HIGH/PERIOD unchanged, clear the counters and return to ARM.
REQ-027 SHALL never wrap the counters; saturation handling per REQ-026 is the only overflow path.
REQ-028 SHALL let a capture win over a simultaneous W1C of VALID (VALID stays 1), and an OVF set win over a simultaneous W1C of OVF.
REQ-029 SHALL return pre-update register values on a read coinciding with a capture.
REQ-030 SHALL capture no period on the first rise after ARM (only arms); VALID sets on the second rise.

Reset
REQ-031 SHALL, with rst=1 at a posedge, force state IDLE, EN=0, VALID=0, OVF=0, HIGH=0, PERIOD=0, counters 0, synchronizer/prev flops 0, mem_ready=0, mem_rdata=0.
REQ-032 SHALL let reset asserted mid-measurement or mid-bus-transaction override everything; mem_ready is not raised for a transaction cut by reset.

Verification
REQ-033 SHALL cover: write CTRL=1, drive pwm_in with P=8, H=2 -> after 2nd rise HIGH=2, PERIOD=8, VALID=1; value updates 3 edges after the rise.
REQ-034 SHALL cover: EN=1, pwm_in stuck 0, WIDTH=8 -> OVF=1 after 255 cycles in MEASURE (following one rise), HIGH/PERIOD unchanged; write STATUS=0x2 -> OVF=0.
REQ-035 SHALL cover: capture and STATUS write 0x1 on the same edge -> VALID remains 1 and the read-back STATUS bit0 = 1.
REQ-036 SHALL cover: clear EN mid-period, then re-enable -> no capture until two fresh rises; prior HIGH/PERIOD retained meanwhile.
REQ-037 SHALL cover: bus read of each address with mem_valid held -> mem_ready high exactly one cycle, one cycle after mem_valid; rdata is correct on that cycle; a write of 0xFFFFFFFF to PERIOD has no effect.
REQ-038 SHALL cover: rst pulsed mid-MEASURE with VALID=1 -> all registers 0 on the next edge; the next capture needs two rises after EN is rewritten.
